uart_bus_arbiter: RTL and testbench
===================================

UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: WAIT-state cycles before a transaction is force-completed (timeout build only).
REQ-002 One clock; reset is asynchronous and active-low: i_clk, i_rst_n.
REQ-003 i_clk  in  1  rising-edge clock.
REQ-004 i_rst_n  in  1  async active-low reset.
REQ-005 i_req0 / i_req1  in  1  requester 0/1 transaction request, level, held until o_dv0/o_dv1.
REQ-006 i_write0 / i_write1  in  1  1 = write, 0 = read.
REQ-007 i_addr0 / i_addr1  in  3  UART register address.
REQ-008 i_wdata0 / i_wdata1  in  8  write data.
REQ-009 o_rdata0 / o_rdata1  out  8  read data, valid with o_dvN.
REQ-010 o_dv0 / o_dv1  out  1  one-cycle completion pulse.
REQ-011 o_err0 / o_err1  out  1  timeout flag, valid with o_dvN.
REQ-012 o_uart_request  out  1  one-cycle request pulse to UART.
REQ-013 o_uart_write / o_uart_address / o_uart_data  out  1/3/8  UART command, held for the whole transaction.
REQ-014 i_uart_data  in  8  UART combinational read data.
REQ-015 i_uart_data_DV  in  1  UART completion, one cycle after o_uart_request.

Function
REQ-016 FSM states IDLE, WAIT, RESP; exactly one transaction in flight.
REQ-017 IDLE: any i_reqN high -> latch winner's write/addr/wdata into o_uart_*, assert o_uart_request for exactly one cycle, go WAIT.
REQ-018 Both requests high in IDLE: grant to the requester not granted last (round-robin); after reset, requester 0 wins first.
REQ-019 Round-robin pointer updates only on grant.
REQ-020 WAIT: on i_uart_data_DV capture i_uart_data into o_rdataN of the granted requester, go RESP; o_uart_address held stable until capture.
REQ-021 RESP: o_dvN high for exactly one cycle for the granted requester only, o_errN valid, then IDLE; requests ignored in RESP.
REQ-022 Latency: i_reqN sampled high at edge 0 -> o_uart_request in cycle 1 -> DV in cycle 2 -> o_dvN in cycle 3.
REQ-023 Write transactions: o_rdataN = 8'h00.
REQ-024 Requester dropping i_reqN in WAIT does not abort; o_dvN still pulses.
REQ-025 i_uart_data_DV outside WAIT is ignored.
REQ-026 o_rdataN of the non-granted requester holds its prior value.
REQ-027 Requester keeping i_reqN high after o_dvN is treated as a new request in the next IDLE cycle.

Reset
REQ-028 i_rst_n low: FSM = IDLE, pointer favours requester 0, all outputs 0, immediately and asynchronously, including mid-transaction; the aborted transaction yields no o_dvN.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined: WAIT counter counts from 0; on reaching TIMEOUT_CYCLES without DV -> RESP with o_rdataN = 8'h00, o_errN = 1; a late DV is ignored per REQ-025.
REQ-030 Macro undefined: no counter, WAIT indefinitely, o_err0/o_err1 tied 0; ports unchanged.

Structure
REQ-031 Package uart_arb_pkg: FSM state encoding, UART address constants (RHR/THR=0, IER=1, ISR/FCR=2, LCR=3, LSR=5), default TIMEOUT_CYCLES.
REQ-032 One sub-module uart_arb_rr: 2-way round-robin grant picker with pointer register.

Verification
REQ-033 Req0 write addr 0 data 8'h41 -> o_uart_request pulse cycle 1 with write=1, addr=0, data=8'h41; o_dv0 cycle 3, o_rdata0 = 8'h00.
REQ-034 Req1 read addr 5 (UART LSR 0) -> o_rdata1 = 8'h20, o_dv1 one cycle, o_dv0 stays 0.
REQ-035 Req0 and Req1 high in same cycle after reset, both held -> grants 0,1,0,1; no overlapping o_uart_request.
REQ-036 UART model never asserts DV, macro defined, TIMEOUT_CYCLES=4 -> o_dv0 with o_err0=1, o_rdata0=8'h00; macro undefined -> no o_dv0 after 100 cycles.
REQ-037 i_rst_n low during WAIT -> outputs 0 at once, no o_dvN; after release, requester 0 wins next simultaneous request.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding, UART register map and timeout default for the bus arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} arb_state_t;
  localparam logic [2:0] UART_RHR = 3'd0;
  localparam logic [2:0] UART_THR = 3'd0;
  localparam logic [2:0] UART_IER = 3'd1;
  localparam logic [2:0] UART_ISR = 3'd2;
  localparam logic [2:0] UART_FCR = 3'd2;
  localparam logic [2:0] UART_LCR = 3'd3;
  localparam logic [2:0] UART_LSR = 3'd5;
  localparam int DEF_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/uart_arb_rr.sv
// uart_arb_rr: two-way round-robin picker; the pointer favours the side not granted last
module uart_arb_rr (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic valid,
  output logic sel
);
  logic prio;
  assign valid = req0 | req1;
  assign sel = (req0 & req1) ? prio : req1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) prio <= 1'b0;
    else if (en && valid) prio <= ~sel;
endmodule

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: shares one UART register port between two requesters, one transaction at a time.
// Define UART_ARB_TIMEOUT_EN to force-complete a stalled WAIT after TIMEOUT_CYCLES with an error flag.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_write0,
  input  logic       i_write1,
  input  logic [2:0] i_addr0,
  input  logic [2:0] i_addr1,
  input  logic [7:0] i_wdata0,
  input  logic [7:0] i_wdata1,
  output logic [7:0] o_rdata0,
  output logic [7:0] o_rdata1,
  output logic       o_dv0,
  output logic       o_dv1,
  output logic       o_err0,
  output logic       o_err1,
  output logic       o_uart_request,
  output logic       o_uart_write,
  output logic [2:0] o_uart_address,
  output logic [7:0] o_uart_data,
  input  logic [7:0] i_uart_data,
  input  logic       i_uart_data_DV
);
  arb_state_t state;
  logic gnt, rr_valid, rr_sel, timeout;
  logic [7:0] cap_data;
  uart_arb_rr u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req0    (i_req0),
    .req1    (i_req1),
    .en      (state == S_IDLE),
    .valid   (rr_valid),
    .sel     (rr_sel)
  );
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else cnt <= (state == S_WAIT && !i_uart_data_DV && !timeout) ? cnt + 1'b1 : '0;
  assign timeout = state == S_WAIT && !i_uart_data_DV && cnt == LAST;
`else
  // WAIT never expires in this build; the comparison is constant false
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  assign cap_data = (o_uart_write || timeout) ? 8'h00 : i_uart_data;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      gnt            <= 1'b0;
      o_uart_request <= 1'b0;
      o_uart_write   <= 1'b0;
      o_uart_address <= 3'd0;
      o_uart_data    <= 8'h00;
      o_rdata0       <= 8'h00;
      o_rdata1       <= 8'h00;
      o_dv0          <= 1'b0;
      o_dv1          <= 1'b0;
      o_err0         <= 1'b0;
      o_err1         <= 1'b0;
    end else begin
      o_uart_request <= 1'b0;
      o_dv0          <= 1'b0;
      o_dv1          <= 1'b0;
      case (state)
        S_IDLE: if (rr_valid) begin
          state          <= S_WAIT;
          gnt            <= rr_sel;
          o_uart_request <= 1'b1;
          o_uart_write   <= rr_sel ? i_write1 : i_write0;
          o_uart_address <= rr_sel ? i_addr1 : i_addr0;
          o_uart_data    <= rr_sel ? i_wdata1 : i_wdata0;
        end
        S_WAIT: if (i_uart_data_DV || timeout) begin
          state <= S_RESP;
          if (gnt) begin
            o_rdata1 <= cap_data;
            o_err1   <= timeout;
            o_dv1    <= 1'b1;
          end else begin
            o_rdata0 <= cap_data;
            o_err0   <= timeout;
            o_dv0    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: directed vector table, corner sequences and a randomized run against a
// transaction-level model (fixed 4-cycle transaction slot, round-robin on contention).
module tb_uart_bus_arbiter;
  import uart_arb_pkg::*;
  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_req0, i_req1, i_write0, i_write1;
  logic [2:0] i_addr0, i_addr1;
  logic [7:0] i_wdata0, i_wdata1, i_uart_data;
  logic [7:0] o_rdata0, o_rdata1, o_uart_data;
  logic o_dv0, o_dv1, o_err0, o_err1, o_uart_request, o_uart_write;
  logic [2:0] o_uart_address;
  logic i_uart_data_DV;
  logic uart_dv = 1'b0;
  logic dv_en, dv_force;
  logic [7:0] uart_mem [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
  int total = 0;
  int passed = 0;
  logic [7:0] rd_exp [2];
  logic [7:0] ref_mem [8];
  int age, n, last_t, cnt;
  logic w_m, fav, cw, got;
  logic [2:0] ca;
  logic [7:0] cd;
  typedef struct {
    logic r;
    logic w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [8];

  always #5 i_clk = ~i_clk;

  uart_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_req1(i_req1), .i_write0(i_write0), .i_write1(i_write1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_dv0(o_dv0), .o_dv1(o_dv1),
    .o_err0(o_err0), .o_err1(o_err1), .o_uart_request(o_uart_request),
    .o_uart_write(o_uart_write), .o_uart_address(o_uart_address), .o_uart_data(o_uart_data),
    .i_uart_data(i_uart_data), .i_uart_data_DV(i_uart_data_DV)
  );

  // UART register model: combinational read, completion one cycle after the request pulse
  assign i_uart_data = uart_mem[o_uart_address];
  assign i_uart_data_DV = uart_dv | dv_force;
  always @(posedge i_clk) begin
    uart_dv <= o_uart_request & dv_en;
    if (uart_dv && o_uart_write && o_uart_address != UART_LSR) uart_mem[o_uart_address] <= o_uart_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {o_dv0, o_dv1, o_err0, o_err1, o_uart_request, o_uart_write, o_uart_address,
               o_uart_data, o_rdata0, o_rdata1}, 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    #1;
    chk_all_zero("reset_outputs");
    rd_exp[0] = 8'h00;
    rd_exp[1] = 8'h00;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic do_txn(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] exp);
    @(negedge i_clk);
    if (r) begin
      i_req1 = 1'b1; i_write1 = w; i_addr1 = a; i_wdata1 = d;
    end else begin
      i_req0 = 1'b1; i_write0 = w; i_addr0 = a; i_wdata0 = d;
    end
    @(negedge i_clk);
    chk("txn_request", o_uart_request, 1);
    chk("txn_command", {o_uart_write, o_uart_address, o_uart_data}, {w, a, d});
    @(negedge i_clk);
    chk("txn_request_pulse", {o_uart_request, o_dv1, o_dv0}, 0);
    @(negedge i_clk);
    chk("txn_dv", {o_dv1, o_dv0}, r ? 2'b10 : 2'b01);
    chk("txn_rdata", r ? o_rdata1 : o_rdata0, exp);
    chk("txn_other_hold", r ? o_rdata0 : o_rdata1, rd_exp[!r]);
    rd_exp[r] = exp;
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    @(negedge i_clk);
    chk("txn_dv_once", {o_dv1, o_dv0}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_req0 = 0; i_req1 = 0; i_write0 = 0; i_write1 = 0;
    i_addr0 = 0; i_addr1 = 0; i_wdata0 = 0; i_wdata1 = 0; dv_en = 1; dv_force = 0;
    vecs[0] = '{1'b0, 1'b1, UART_THR, 8'h41, 8'h00};
    vecs[1] = '{1'b1, 1'b0, UART_LSR, 8'h00, 8'h20};
    vecs[2] = '{1'b1, 1'b1, UART_LCR, 8'h83, 8'h00};
    vecs[3] = '{1'b0, 1'b0, UART_LCR, 8'h00, 8'h83};
    vecs[4] = '{1'b1, 1'b0, UART_RHR, 8'h00, 8'h41};
    vecs[5] = '{1'b0, 1'b1, 3'd7, 8'h5a, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 3'd7, 8'h00, 8'h5a};
    vecs[7] = '{1'b0, 1'b0, UART_LSR, 8'h00, 8'h20};
    reset_dut();
    for (int i = 0; i < 8; i++) do_txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
    // stray completion while idle
    @(negedge i_clk);
    dv_force = 1'b1;
    @(negedge i_clk);
    dv_force = 1'b0;
    chk("stray_dv_no_resp", {o_dv1, o_dv0}, 0);
    chk("stray_dv_rdata", {o_rdata1, o_rdata0}, {rd_exp[1], rd_exp[0]});
    @(negedge i_clk);
    chk("stray_dv_no_resp_late", {o_dv1, o_dv0}, 0);
    // requester withdraws during WAIT
    @(negedge i_clk);
    i_req1 = 1'b1; i_write1 = 1'b0; i_addr1 = UART_LCR;
    @(negedge i_clk);
    chk("drop_request", o_uart_request, 1);
    i_req1 = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("drop_dv", {o_dv1, o_dv0}, 2'b10);
    chk("drop_rdata", o_rdata1, 8'h83);
    rd_exp[1] = 8'h83;
    @(negedge i_clk);
    // silent UART
    dv_en = 1'b0;
    @(negedge i_clk);
    i_req0 = 1'b1; i_write0 = 1'b0; i_addr0 = UART_IER;
`ifdef UART_ARB_TIMEOUT_EN
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 20) begin
      @(negedge i_clk);
      cnt++;
      got = o_dv0;
    end
    chk("timeout_dv", got, 1);
    chk("timeout_err", o_err0, 1);
    chk("timeout_rdata", o_rdata0, 8'h00);
    chk("timeout_dv1", o_dv1, 0);
    i_req0 = 1'b0;
    dv_en = 1'b1;
    repeat (2) @(negedge i_clk);
`else
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_dv0 || o_dv1) cnt++;
    end
    chk("no_timeout_dv", cnt, 0);
    chk("no_timeout_err", {o_err1, o_err0}, 0);
    dv_en = 1'b1;
    reset_dut();
`endif
    // contention: both held, grants must alternate starting at 0
    reset_dut();
    @(negedge i_clk);
    i_req0 = 1'b1; i_write0 = 1'b0; i_addr0 = UART_IER;
    i_req1 = 1'b1; i_write1 = 1'b0; i_addr1 = UART_LCR;
    n = 0;
    last_t = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge i_clk);
      if (o_uart_request) begin
        chk("rr_order", o_uart_address, (n % 2) ? UART_LCR : UART_IER);
        if (n > 0) chk("rr_gap", c - last_t, 4);
        last_t = c;
        n++;
      end
    end
    chk("rr_grants", n, 4);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    repeat (5) @(negedge i_clk);
    // reset mid-transaction
    reset_dut();
    @(negedge i_clk);
    i_req0 = 1'b1; i_write0 = 1'b0; i_addr0 = UART_IER;
    @(negedge i_clk);
    chk("abort_started", o_uart_request, 1);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("abort_async_clear");
    i_req1 = 1'b1; i_write1 = 1'b0; i_addr1 = UART_LCR;
    repeat (2) begin
      @(negedge i_clk);
      chk("abort_no_dv", {o_dv1, o_dv0}, 0);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("abort_winner", {o_uart_request, o_uart_address}, {1'b1, UART_IER});
    chk("abort_no_stale_dv", {o_dv1, o_dv0}, 0);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    repeat (5) @(negedge i_clk);
    // randomized traffic against the transaction-level model
    reset_dut();
    for (int i = 0; i < 8; i++) ref_mem[i] = uart_mem[i];
    fav = 1'b0;
    age = 0;
    w_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge i_clk);
      if (age == 0) begin
        if (i_req0 || i_req1) begin
          w_m = (i_req0 && i_req1) ? fav : i_req1;
          fav = !w_m;
          cw = w_m ? i_write1 : i_write0;
          ca = w_m ? i_addr1 : i_addr0;
          cd = w_m ? i_wdata1 : i_wdata0;
          age = 1;
        end
      end else age = (age == 3) ? 0 : age + 1;
      @(negedge i_clk);
      chk("rnd_request", o_uart_request, age == 1);
      chk("rnd_dv", {o_dv1, o_dv0}, (age == 3) ? (w_m ? 2'b10 : 2'b01) : 2'b00);
      if (age == 1) chk("rnd_command", {o_uart_write, o_uart_address, o_uart_data}, {cw, ca, cd});
      if (age == 3) begin
        rd_exp[w_m] = cw ? 8'h00 : ref_mem[ca];
        if (cw && ca != UART_LSR) ref_mem[ca] = cd;
        if (w_m) i_req1 = 1'($urandom_range(1));
        else i_req0 = 1'($urandom_range(1));
        if (w_m) begin
          i_write1 = 1'($urandom_range(1)); i_addr1 = 3'($urandom_range(7)); i_wdata1 = 8'($urandom);
        end else begin
          i_write0 = 1'($urandom_range(1)); i_addr0 = 3'($urandom_range(7)); i_wdata0 = 8'($urandom);
        end
      end
      chk("rnd_rdata", {o_rdata1, o_rdata0}, {rd_exp[1], rd_exp[0]});
      chk("rnd_err", {o_err1, o_err0}, 0);
      if (!i_req0 && $urandom_range(2) == 0) begin
        i_req0 = 1'b1; i_write0 = 1'($urandom_range(1)); i_addr0 = 3'($urandom_range(7)); i_wdata0 = 8'($urandom);
      end
      if (!i_req1 && $urandom_range(2) == 0) begin
        i_req1 = 1'b1; i_write1 = 1'($urandom_range(1)); i_addr1 = 3'($urandom_range(7)); i_wdata1 = 8'($urandom);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
